// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window stream: tap count, tap indices
// and the bit offset of each tap inside the packed window word.
package win_pkg;

    localparam int WIN_TAPS = 9;

    // Tap indices, p1 (top-left) through p9 (bottom-right), in raster order.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P3 = 2;
    localparam int P4 = 3;
    localparam int P5 = 4;
    localparam int P6 = 5;
    localparam int P7 = 6;
    localparam int P8 = 7;
    localparam int P9 = 8;

    // Lowest bit of a tap inside the packed window (p1 sits in the LSBs).
    function automatic int tap_lo(input int tap, input int pix_w);
        return tap * pix_w;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. A single address serves both the read
// and the write of a cycle; the read returns the value held before the write.
module line_buffer #(
    parameter  int DEPTH = 66,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port. NOTE: the storage has no reset; every location is written
    // before it is ever emitted, and a reset term would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read is combinational, so it sees the old contents in the write cycle.
    assign rdata = mem[addr];

endmodule

// File: rtl/window_stream_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed the right
// column of a 3x3 shift window; one window is emitted per interior pixel.
module window_stream_3x3
    import win_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 66,
    parameter int IMG_H = 66
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIX_W-1:0]          in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIN_TAPS*PIX_W-1:0] out_win,
    output logic                      out_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             emit;
    logic             col_end;
    logic             row_end;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // win[r][c]: r = 0 top row, c = 0 left column.
    logic [PIX_W-1:0]            win     [3][3];
    logic [PIX_W-1:0]            win_nxt [3][3];
    logic [WIN_TAPS*PIX_W-1:0]   win_flat;

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col == COL_W'(IMG_W - 1));
    assign row_end  = (row == ROW_W'(IMG_H - 1));
    assign emit     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // lb0 holds the previous row, lb1 the row before that.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (in_pixel),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Next window: shift left, new right column from the buffers and the input.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
            win_nxt[r][2] = '0;
        end
        win_nxt[0][2] = lb1_rd;
        win_nxt[1][2] = lb0_rd;
        win_nxt[2][2] = in_pixel;

        win_flat = '0;
        win_flat[tap_lo(P1, PIX_W) +: PIX_W] = win_nxt[0][0];
        win_flat[tap_lo(P2, PIX_W) +: PIX_W] = win_nxt[0][1];
        win_flat[tap_lo(P3, PIX_W) +: PIX_W] = win_nxt[0][2];
        win_flat[tap_lo(P4, PIX_W) +: PIX_W] = win_nxt[1][0];
        win_flat[tap_lo(P5, PIX_W) +: PIX_W] = win_nxt[1][1];
        win_flat[tap_lo(P6, PIX_W) +: PIX_W] = win_nxt[1][2];
        win_flat[tap_lo(P7, PIX_W) +: PIX_W] = win_nxt[2][0];
        win_flat[tap_lo(P8, PIX_W) +: PIX_W] = win_nxt[2][1];
        win_flat[tap_lo(P9, PIX_W) +: PIX_W] = win_nxt[2][2];
    end

    // Raster position of the next pixel to be accepted.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (flush) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // 3x3 shift window; contents straddling a row wrap are never emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (flush) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win <= win_nxt;
        end
    end

    // Output register: loads on a qualifying accept, holds until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_last  <= row_end && col_end;
            out_win   <= win_flat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_stream_3x3.sv
// Bench for window_stream_3x3: a 4x4 instance for directed scenarios and a
// 66x66 instance for a random frame, both checked against a frame-image model.
module tb_window_stream_3x3;

    localparam int PW = 8;
    localparam int BW = 66;
    localparam int BH = 66;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic           s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic [PW-1:0]  s_in_pixel;
    logic [9*PW-1:0] s_out_win;

    logic           b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [PW-1:0]  b_in_pixel;
    logic [9*PW-1:0] b_out_win;

    window_stream_3x3 #(.PIX_W(PW), .IMG_W(4), .IMG_H(4)) u_small (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_win(s_out_win), .out_last(s_out_last)
    );

    window_stream_3x3 #(.PIX_W(PW), .IMG_W(BW), .IMG_H(BH)) u_big (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_win(b_out_win), .out_last(b_out_last)
    );

    typedef struct packed {
        logic [9*PW-1:0] win;
        logic            last;
    } exp_t;

    exp_t s_q[$];
    exp_t b_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int s_hs = 0, s_lasts = 0, b_hs = 0, b_lasts = 0;
    bit abort = 1'b0;

    logic [PW-1:0] s_img [4][4];
    logic [PW-1:0] b_img [BH][BW];

    logic [9*PW-1:0] s_hold, b_hold;
    bit s_stall = 1'b0, b_stall = 1'b0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] s_window(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = s_img[r-2+k/3][c-2+k%3];
        return w;
    endfunction

    function automatic logic [71:0] b_window(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = b_img[r-2+k/3][c-2+k%3];
        return w;
    endfunction

    // Output monitor: scoreboard pops on handshake, hold/backpressure checks on stall.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !s_flush) begin
            if (s_stall && s_out_valid) check("s_hold_win", s_out_win, s_hold);
            if (s_out_valid && !s_out_ready) begin
                check("s_stall_in_ready", 72'(s_in_ready), 72'd0);
                s_stall = 1'b1;
                s_hold  = s_out_win;
            end else begin
                s_stall = 1'b0;
            end
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    check("s_unexpected_window", 72'(s_out_valid), 72'd0);
                end else begin
                    e = s_q.pop_front();
                    check("s_win", s_out_win, e.win);
                    check("s_last", 72'(s_out_last), 72'(e.last));
                    s_hs++;
                    if (s_out_last) s_lasts++;
                end
            end
        end else begin
            s_stall = 1'b0;
        end

        if (rst_n && !b_flush) begin
            if (b_stall && b_out_valid) check("b_hold_win", b_out_win, b_hold);
            if (b_out_valid && !b_out_ready) begin
                check("b_stall_in_ready", 72'(b_in_ready), 72'd0);
                b_stall = 1'b1;
                b_hold  = b_out_win;
            end else begin
                b_stall = 1'b0;
            end
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected_window", 72'(b_out_valid), 72'd0);
                end else begin
                    e = b_q.pop_front();
                    check("b_win", b_out_win, e.win);
                    check("b_last", 72'(b_out_last), 72'(e.last));
                    b_hs++;
                    if (b_out_last) b_lasts++;
                end
            end
        end else begin
            b_stall = 1'b0;
        end
    end

    // Present one pixel to the 4x4 instance at raster index idx and wait for its accept.
    task automatic s_send(input logic [PW-1:0] pix, input int idx);
        int r, c, t;
        bit ok;
        exp_t e;
        r = idx / 4;
        c = idx % 4;
        t = 0;
        ok = 1'b0;
        s_in_valid = 1'b1;
        s_in_pixel = pix;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = s_in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            check("s_accept_timeout", 72'(s_in_ready), 72'd1);
            return;
        end
        s_img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            e.win  = s_window(r, c);
            e.last = (r == 3 && c == 3);
            s_q.push_back(e);
            check("s_latency_valid", 72'(s_out_valid), 72'd1);
        end
    endtask

    // Stream a full 4x4 frame; optionally stall the consumer for 5 cycles after index stall_after.
    task automatic s_stream(input int base, input int stall_after);
        for (int i = 0; i < 16; i++) begin
            s_send(8'(base + i), i);
            if (i == stall_after) begin
                s_out_ready = 1'b0;
                s_in_valid  = 1'b1;
                s_in_pixel  = 8'(base + i + 1);
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                s_out_ready = 1'b1;
            end
        end
    endtask

    task automatic s_drain(input string tag, input int h0, input int l0, input int nwin, input int nlast);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_windows"}, 72'(s_hs - h0), 72'(nwin));
        check({tag, "_lasts"}, 72'(s_lasts - l0), 72'(nlast));
        check({tag, "_queue_empty"}, 72'(s_q.size()), 72'd0);
    endtask

    // Present one pixel to the 66x66 instance, randomising out_ready each waiting cycle.
    task automatic b_send(input logic [PW-1:0] pix, input int r, input int c);
        int t;
        bit ok;
        exp_t e;
        t = 0;
        ok = 1'b0;
        b_in_valid = 1'b1;
        b_in_pixel = pix;
        while (!ok && t < 200) begin
            b_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = b_in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            check("b_accept_timeout", 72'(b_in_ready), 72'd1);
            abort = 1'b1;
            return;
        end
        b_img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            e.win  = b_window(r, c);
            e.last = (r == BH - 1 && c == BW - 1);
            b_q.push_back(e);
            check("b_latency_valid", 72'(b_out_valid), 72'd1);
        end
    endtask

    initial begin
        int h0, l0, nidle;
        rst_n = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_pixel = '0; s_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_pixel = '0; b_out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_s_out_valid", 72'(s_out_valid), 72'd0);
        check("rst_s_out_last", 72'(s_out_last), 72'd0);
        check("rst_s_out_win", s_out_win, 72'd0);
        check("rst_b_out_valid", 72'(b_out_valid), 72'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: single 4x4 frame, consumer always ready
        h0 = s_hs; l0 = s_lasts;
        s_stream(0, -1);
        s_in_valid = 1'b0;
        s_drain("sc1", h0, l0, 4, 1);

        // Scenario 2: consumer stalls 5 cycles after the first window
        h0 = s_hs; l0 = s_lasts;
        s_stream(0, 10);
        s_in_valid = 1'b0;
        s_drain("sc2", h0, l0, 4, 1);

        // Scenario 3: two frames back to back
        h0 = s_hs; l0 = s_lasts;
        s_stream(0, -1);
        s_stream(100, -1);
        s_in_valid = 1'b0;
        s_drain("sc3", h0, l0, 8, 2);

        // Scenario 4: asynchronous reset after pixel 9, then a clean frame
        for (int i = 0; i < 10; i++) s_send(8'(i), i);
        s_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("sc4_rst_out_valid", 72'(s_out_valid), 72'd0);
        check("sc4_rst_out_last", 72'(s_out_last), 72'd0);
        check("sc4_rst_out_win", s_out_win, 72'd0);
        s_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        h0 = s_hs; l0 = s_lasts;
        s_stream(0, -1);
        s_in_valid = 1'b0;
        s_drain("sc4", h0, l0, 4, 1);

        // Scenario 5a: flush discards a pending, unconsumed final window
        h0 = s_hs; l0 = s_lasts;
        s_stream(0, -1);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b0;
        check("sc5a_pending_valid", 72'(s_out_valid), 72'd1);
        s_flush    = 1'b1;
        s_in_valid = 1'b1;
        s_in_pixel = 8'hee;
        @(negedge clk);
        check("sc5a_flush_in_ready", 72'(s_in_ready), 72'd0);
        @(posedge clk);
        #1;
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        s_q.delete();
        check("sc5a_flushed_valid", 72'(s_out_valid), 72'd0);
        check("sc5a_flushed_last", 72'(s_out_last), 72'd0);
        s_out_ready = 1'b1;
        s_drain("sc5a", h0, l0, 3, 0);

        // Scenario 5b: flush on pixel 7 drops it; the next frame restarts at (0,0)
        for (int i = 0; i < 7; i++) s_send(8'(i), i);
        s_flush    = 1'b1;
        s_in_valid = 1'b1;
        s_in_pixel = 8'd7;
        @(negedge clk);
        check("sc5b_flush_in_ready", 72'(s_in_ready), 72'd0);
        @(posedge clk);
        #1;
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        s_q.delete();
        check("sc5b_flushed_valid", 72'(s_out_valid), 72'd0);
        h0 = s_hs; l0 = s_lasts;
        s_stream(0, -1);
        s_in_valid = 1'b0;
        s_drain("sc5b", h0, l0, 4, 1);

        // Scenario 6: random 66x66 frame with random valid and ready
        for (int idx = 0; idx < BW * BH; idx++) begin
            if (abort) break;
            nidle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            b_in_valid = 1'b0;
            for (int k = 0; k < nidle; k++) begin
                b_out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
            b_send(8'($urandom_range(0, 255)), idx / BW, idx % BW);
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("sc6_windows", 72'(b_hs), 72'((BW - 2) * (BH - 2)));
        check("sc6_lasts", 72'(b_lasts), 72'd1);
        check("sc6_queue_empty", 72'(b_q.size()), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_stream_3x3.md
Name: window_stream_3x3

Overview:
- Streaming 3x3 neighbourhood generator. It replaces the whole-frame read array of the filter memory with two line buffers and a 3x3 shift window.
- Accepts a raster-order pre-padded image of IMG_W x IMG_H pixels and emits one 3x3 window per interior position, (IMG_W-2) x (IMG_H-2) windows per frame.
- Sits between the pixel source and the convolution datapath, with valid/ready on both sides.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 66, padded frame width in pixels (>=3).
- IMG_H, 66, padded frame height in pixels (>=3).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous frame restart; clears counters and window state.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pixel  in  PIX_W  input pixel, raster order.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- out_win  out  9*PIX_W  window packing:
  - bits [PIX_W-1:0] = p1 (top-left); then p2, p3 across the top row.
  - p4..p6 form the middle row; p7..p9 form the bottom row.
  - p9 (bottom-right) is in the MSBs.
- out_last  out  1  qualifies the final window of a frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_last=0, out_win=0.
  - col and row counters = 0.
  - Window registers = 0.
  - Line buffer contents are don't-care.
- in_ready = !out_valid || out_ready, i.e. a single output register with pass-through backpressure. It is low while flush is asserted.
- An input pixel is accepted when in_valid && in_ready.
- On each accept:
  - Line buffer 1 at [col] takes line buffer 0 at [col].
  - Line buffer 0 at [col] takes in_pixel.
  - Window shifts one column left.
  - New right column = {lb1[col], lb0[col], in_pixel}, top to bottom, using pre-write buffer values.
- Counters:
  - col counts 0..IMG_W-1.
  - row increments when col wraps.
  - After pixel (IMG_H-1, IMG_W-1), both counters return to 0. The next frame starts with no gap or idle cycle.
- Window emission:
  - A window is emitted when the accepted pixel satisfies row>=2 && col>=2.
  - On the cycle after the accept: out_valid=1, out_win = window whose bottom-right is that pixel.
  - Latency is 1 cycle from accept to out_valid.
  - out_last=1 when the emitting pixel is (IMG_H-1, IMG_W-1).
- Output register:
  - Once out_valid is asserted, out_win and out_last hold stable until out_valid && out_ready.
  - On handshake with no new qualifying accept in the same cycle, out_valid drops to 0 next cycle.
  - Accept and output handshake in the same cycle: the register reloads, throughput is 1 window/cycle.
- Accepts with col<2 or row<2 only fill buffers and window; out_valid is unaffected.
- Row wrap: window contents crossing col wrap are garbage. They are never emitted because of the col>=2 gate, so no explicit clear is needed.
- flush (synchronous, highest priority after reset):
  - Counters=0, out_valid=0, out_last=0, window=0.
  - A pixel presented in the same cycle is dropped.
  - A pending un-accepted window is discarded.
- Reset mid-frame: all state is lost; the next accepted pixel is treated as (0,0).
- Width rules:
  - col width = $clog2(IMG_W); row width = $clog2(IMG_H).
  - No arithmetic on pixel data; values pass through bit-exact.
- Line buffers: two IMG_W x PIX_W arrays, single write port and single read port each, read and write at the same address in the same cycle. Read-before-write semantics are required.

Decomposition:
- Shared package win_pkg: WIN_TAPS=9, the tap-index constants P1..P9, and a function for tap slice offset.
- One natural sub-module, line_buffer: parameters DEPTH and WIDTH, one read/write port, read-before-write. It is instantiated twice.
- Counters, window and output register stay in the top module.

Test Plan:
1. IMG_W=4, IMG_H=4, pixels 0..15 streamed with out_ready=1 -> exactly 4 windows:
   - 1st {0,1,2,4,5,6,8,9,10}, p1..p9.
   - Each one cycle after accepting 10, 11, 14, 15.
   - out_last only on {5,6,7,9,10,11,13,14,15}.
2. Same stream, out_ready held low for 5 cycles after the first window -> out_win stable, in_ready=0 for those cycles, no window lost or duplicated, total still 4.
3. Two back-to-back 4x4 frames with values 0..15 then 100..115 -> second frame's first window is {100,101,102,104,105,106,108,109,110}, out_last twice.
4. rst_n pulsed low asynchronously after pixel 9 of a frame, then 0..15 restreamed -> outputs 0 during reset, then the same 4 windows as scenario 1.
5. flush asserted with in_valid=1 on pixel 7, then 0..15 streamed -> pixel 7 dropped, pending output cleared, subsequent windows match scenario 1.
6. Default 66x66 random frame with random in_valid/out_ready -> 4096 windows matching a reference model, out_last exactly once.
